// File: rtl/hypot_dispatcher.sv
// Queues operand pairs for the non-pipelined math_unit hypotenuse engine, issues them one at a
// time over start/busy, and returns 9-bit results in arrival order through an output FIFO.
module hypot_dispatcher #(
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_a_bi,
    input  logic [7:0] in_b_bi,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [8:0] out_y_bo,
    output logic [7:0] mu_a_bo,
    output logic [7:0] mu_b_bo,
    output logic       mu_start_o,
    input  logic       mu_busy_i,
    input  logic [8:0] mu_y_bi,
    output logic       inflight_o
);
    localparam int unsigned IPW = $clog2(IN_DEPTH);
    localparam int unsigned OPW = $clog2(OUT_DEPTH);
    localparam logic [IPW:0] InFull  = IN_DEPTH[IPW:0];
    localparam logic [OPW:0] OutFull = OUT_DEPTH[OPW:0];

    typedef enum logic [1:0] {StIdle, StIssue, StArm, StWait} state_e;

    state_e         state_q;
    logic [7:0]     mu_a_q, mu_b_q;
    logic           mu_start_q;

    logic [7:0]     in_a_mem_q [IN_DEPTH];
    logic [7:0]     in_b_mem_q [IN_DEPTH];
    logic [IPW-1:0] in_wr_q, in_rd_q;
    logic [IPW:0]   in_cnt_q;

    logic [8:0]     out_mem_q [OUT_DEPTH];
    logic [OPW-1:0] out_wr_q, out_rd_q;
    logic [OPW:0]   out_cnt_q;

    logic           in_push, in_pop, out_push, out_pop, credit_ok;
    logic [OPW+1:0] credit_sum;

    always_comb begin
        inflight_o  = (state_q != StIdle);
        in_ready_o  = (in_cnt_q < InFull);
        out_valid_o = (out_cnt_q != '0);
        out_y_bo    = out_valid_o ? out_mem_q[out_rd_q] : 9'd0;
        mu_a_bo     = mu_a_q;
        mu_b_bo     = mu_b_q;
        mu_start_o  = mu_start_q;
        credit_sum  = {1'b0, out_cnt_q} + {{(OPW + 1){1'b0}}, inflight_o};
        credit_ok   = (credit_sum < {1'b0, OutFull});
        in_push     = in_valid_i & in_ready_o;
        in_pop      = (state_q == StIdle) & (in_cnt_q != '0) & credit_ok;
        out_push    = (state_q == StWait) & ~mu_busy_i;
        out_pop     = out_valid_o & out_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            if (in_push) begin
                in_a_mem_q[in_wr_q] <= in_a_bi;
                in_b_mem_q[in_wr_q] <= in_b_bi;
                in_wr_q             <= in_wr_q + IPW'(1);
            end
            if (in_pop) in_rd_q <= in_rd_q + IPW'(1);
            unique case ({in_push, in_pop})
                2'b10:   in_cnt_q <= in_cnt_q + (IPW + 1)'(1);
                2'b01:   in_cnt_q <= in_cnt_q - (IPW + 1)'(1);
                default: in_cnt_q <= in_cnt_q;
            endcase
        end
    end

    // Credit check at issue time guarantees a slot for every push, so no full guard here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_push) begin
                out_mem_q[out_wr_q] <= mu_y_bi;
                out_wr_q            <= out_wr_q + OPW'(1);
            end
            if (out_pop) out_rd_q <= out_rd_q + OPW'(1);
            unique case ({out_push, out_pop})
                2'b10:   out_cnt_q <= out_cnt_q + (OPW + 1)'(1);
                2'b01:   out_cnt_q <= out_cnt_q - (OPW + 1)'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            mu_a_q     <= '0;
            mu_b_q     <= '0;
            mu_start_q <= 1'b0;
        end else begin
            mu_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_pop) begin
                        mu_a_q     <= in_a_mem_q[in_rd_q];
                        mu_b_q     <= in_b_mem_q[in_rd_q];
                        mu_start_q <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: state_q <= StArm;
                // Busy low in ARM is engine start-up latency, not completion.
                StArm: if (mu_busy_i) state_q <= StWait;
                StWait: if (!mu_busy_i) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_hypot_dispatcher.sv
// Bench for hypot_dispatcher: behavioural math_unit, queue-based reference model and directed
// plus randomized stimulus.
module tb_hypot_dispatcher;
    localparam int ID = 4;
    localparam int OD = 4;

    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic       in_ready, out_valid, mu_start, infl;
    logic [8:0] out_y;
    logic [7:0] mu_a, mu_b;
    logic       mu_busy = 1'b0;
    logic [8:0] mu_y = '0;

    int vectors = 0, errors = 0;
    int lat_max = 4, eng_cnt = 0;
    int incnt, outcnt, n_start = 0;
    bit push_p, pop_p, comp_p, seen_busy, prev_start, prev_infl, chk_rst, done;
    logic [7:0] pa, pb;
    int exp_q[$], got_q[$];
    logic [15:0] op_q[$];

    hypot_dispatcher #(.IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_bi(in_a), .in_b_bi(in_b), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_y_bo(out_y), .mu_a_bo(mu_a), .mu_b_bo(mu_b), .mu_start_o(mu_start),
        .mu_busy_i(mu_busy), .mu_y_bi(mu_y), .inflight_o(infl)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int a, input int b);
        int s, r;
        s = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic fail_now(input string n);
        vectors++;
        errors++;
        $display("FAIL %s: bound expired or model queue empty", n);
    endtask

    // math_unit stand-in: busy rises the cycle after start, falls after a random busy time.
    always @(posedge clk) begin
        if (rst) begin
            mu_busy <= 1'b0;
            eng_cnt <= 0;
        end else if (mu_start) begin
            mu_busy <= 1'b1;
            eng_cnt <= $urandom_range(lat_max, 1);
            mu_y    <= 9'(isqrt(int'(mu_a), int'(mu_b)));
        end else if (mu_busy) begin
            if (eng_cnt <= 1) mu_busy <= 1'b0;
            else eng_cnt <= eng_cnt - 1;
        end
    end

    // Reference model and compare: occupancies derived from observed handshakes only.
    always @(negedge clk) begin
        if (rst) begin
            incnt = 0; outcnt = 0; push_p = 0; pop_p = 0; comp_p = 0;
            seen_busy = 0; prev_start = 0; prev_infl = 0; chk_rst = 1;
            exp_q.delete(); op_q.delete();
        end else begin
            if (push_p) incnt++;
            if (comp_p) outcnt++;
            if (pop_p) outcnt--;
            if (infl && !prev_infl) incnt--;
            if (chk_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_y", out_y, 0);
                chk("rst_mu_a", mu_a, 0);
                chk("rst_mu_b", mu_b, 0);
                chk("rst_start", mu_start, 0);
                chk("rst_inflight", infl, 0);
                chk_rst = 0;
            end
            chk("in_ready", in_ready, incnt < ID);
            chk("out_valid", out_valid, outcnt != 0);
            if (!out_valid) chk("out_y_idle", out_y, 0);
            chk("credit", (outcnt + int'(infl)) <= OD, 1);
            if (mu_start) begin
                chk("start_while_busy", mu_busy, 0);
                chk("start_inflight", infl, 1);
                n_start++;
                if (op_q.size() == 0) fail_now("start_unexpected");
                else chk("issue_operands", {mu_a, mu_b}, op_q.pop_front());
            end
            if (prev_start) chk("start_pulse", mu_start, 0);
            if (infl && prev_infl) begin
                chk("mu_a_stable", mu_a, pa);
                chk("mu_b_stable", mu_b, pb);
            end
            pop_p = out_valid && out_ready;
            if (pop_p) begin
                got_q.push_back(int'(out_y));
                if (exp_q.size() == 0) fail_now("out_unexpected");
                else chk("out_y", out_y, exp_q.pop_front());
            end
            push_p = in_valid && in_ready;
            if (push_p) begin
                exp_q.push_back(isqrt(int'(in_a), int'(in_b)));
                op_q.push_back({in_a, in_b});
            end
            comp_p = 0;
            if (mu_busy) seen_busy = 1;
            else if (seen_busy && infl) begin
                comp_p = 1;
                seen_busy = 0;
            end
            prev_start = mu_start; prev_infl = infl; pa = mu_a; pb = mu_b;
        end
    end

    task automatic push(input int a, input int b);
        int t;
        bit acc;
        in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b);
        t = 0; acc = 0;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) fail_now("push_timeout");
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || infl || incnt != 0) && t < 4000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 4000) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, t;
        int ord[4];
        ord = '{0, 360, 10, 13};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic (3,4)
        out_ready = 1'b1; got_q.delete(); s0 = n_start;
        push(3, 4);
        wait_idle();
        chk("basic_starts", n_start - s0, 1);
        chk("basic_mu_a", mu_a, 3);
        chk("basic_mu_b", mu_b, 4);
        chk("basic_n", got_q.size(), 1);
        if (got_q.size() > 0) chk("basic_y", got_q[0], 5);
        chk("basic_empty", out_valid, 0);

        // Ordering
        got_q.delete();
        push(0, 0); push(255, 255); push(6, 8); push(5, 12);
        wait_idle();
        chk("order_n", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("order_y", got_q[i], ord[i]);

        // Backpressure
        out_ready = 1'b0; got_q.delete(); s0 = n_start;
        for (int i = 1; i <= 6; i++) push(i, 0);
        repeat (80) @(posedge clk);
        #1;
        chk("bp_starts", n_start - s0, 4);
        chk("bp_inflight", infl, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", out_y, 1);
        out_ready = 1'b1;
        wait_idle();
        chk("bp_n", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk("bp_y", got_q[i], i + 1);

        // Reset during WAIT with two queued
        lat_max = 20;
        push(1, 1); push(2, 2); push(3, 3);
        t = 0;
        while (!mu_busy && t < 100) begin @(posedge clk); #1; t++; end
        if (!mu_busy) fail_now("rst_wait_busy");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
        lat_max = 4;
        @(posedge clk); #1;
        push(8, 15);
        wait_idle();
        chk("rst_new_n", got_q.size(), 1);
        if (got_q.size() > 0) chk("rst_new_y", got_q[0], 17);

        // Randomized traffic with random consumer stalls
        lat_max = 5; done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    push(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
                    if ($urandom_range(3, 0) == 0) begin
                        repeat ($urandom_range(6, 1)) @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(2, 0) != 0);
                    if ($urandom_range(15, 0) == 0) out_ready = 1'b0;
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();
        chk("final_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
